// File: rtl/hub75_pkg.sv
// rtl/hub75_pkg.sv - shared defaults and FSM state type for the HUB75 panel receiver
package hub75_pkg;

  localparam int COLS_DEFAULT  = 32;
  localparam int ROW_W_DEFAULT = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

endpackage

// File: rtl/hub75_sync.sv
// rtl/hub75_sync.sv - 2-flop synchronizer with a one-cycle rising-edge pulse
module hub75_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= d;
      sync <= meta;
      prev <= sync;
    end
  end

  assign q    = sync;
  assign rise = sync & ~prev;

endmodule

// File: rtl/hub75_panel_rx.sv
// rtl/hub75_panel_rx.sv - HUB75 panel input receiver: shift, latch into a line buffer, drain as pixel beats
module hub75_panel_rx
  import hub75_pkg::*;
#(
  parameter int COLS  = COLS_DEFAULT,
  parameter int ROW_W = ROW_W_DEFAULT,
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hub_clk,
  input  logic             hub_lat,
  input  logic             hub_oe,
  input  logic [ROW_W-1:0] hub_addr,
  input  logic [2:0]       hub_rgb0,
  input  logic [2:0]       hub_rgb1,
  output logic             px_valid,
  input  logic             px_ready,
  output logic [ROW_W:0]   px_row,
  output logic [CW-1:0]    px_col,
  output logic [2:0]       px_rgb,
  output logic             line_done,
  output logic             err_len,
  output logic             err_overrun,
  output logic             err_oe
);

  localparam int NW = $clog2(COLS + 2);
  localparam int DW = ROW_W + 6;
  localparam logic [NW-1:0] CNT_ONE   = NW'(1);
  localparam logic [NW-1:0] CNT_FULL  = NW'(COLS);
  localparam logic [NW-1:0] CNT_SAT   = NW'(COLS + 1);
  localparam logic [CW:0]   BEAT_ONE  = (CW + 1)'(1);
  localparam logic [CW:0]   BEAT_LAST = (CW + 1)'(2 * COLS - 1);

  logic sclk_rise;
  logic lat_rise;
  logic oe_lvl;
  logic unused_clk_lvl;
  logic unused_lat_lvl;
  logic unused_oe_rise;

  hub75_sync u_sync_clk (
    .clk  (clk),
    .rst  (rst),
    .d    (hub_clk),
    .q    (unused_clk_lvl),
    .rise (sclk_rise)
  );

  hub75_sync u_sync_lat (
    .clk  (clk),
    .rst  (rst),
    .d    (hub_lat),
    .q    (unused_lat_lvl),
    .rise (lat_rise)
  );

  hub75_sync u_sync_oe (
    .clk  (clk),
    .rst  (rst),
    .d    (hub_oe),
    .q    (oe_lvl),
    .rise (unused_oe_rise)
  );

  // Data and address share the control synchronizer depth so they are settled when the edge pulse fires.
  logic [DW-1:0]    dat_meta;
  logic [DW-1:0]    dat_sync;
  logic [ROW_W-1:0] addr_s;
  logic [5:0]       pix_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dat_meta <= '0;
      dat_sync <= '0;
    end else begin
      dat_meta <= {hub_addr, hub_rgb1, hub_rgb0};
      dat_sync <= dat_meta;
    end
  end

  assign addr_s = dat_sync[DW-1:6];
  assign pix_s  = dat_sync[5:0];

  logic [COLS-1:0][5:0] shreg;
  logic [COLS-1:0][5:0] shreg_nxt;
  logic [COLS-1:0][5:0] lbuf;
  logic [NW-1:0]        cnt;
  logic [NW-1:0]        cnt_nxt;

  // Newest pixel enters at the top so the first of COLS shifts ends up in column 0.
  always_comb begin
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    if (sclk_rise) begin
      shreg_nxt = {pix_s, shreg[COLS-1:1]};
      if (cnt != CNT_SAT) begin
        cnt_nxt = cnt + CNT_ONE;
      end
    end
  end

  state_e           state_q;
  state_e           state_d;
  logic             take_line;
  logic             accept;
  logic             last_beat;
  logic             overrun;
  logic [CW:0]      beat;
  logic [ROW_W-1:0] addr_q;

  assign accept    = (state_q == DRAIN) && px_ready;
  assign last_beat = (beat == BEAT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A latch coinciding with the final accepted beat starts the next line without an idle gap.
  always_comb begin
    state_d   = state_q;
    take_line = 1'b0;
    case (state_q)
      IDLE: begin
        if (lat_rise) begin
          state_d   = DRAIN;
          take_line = 1'b1;
        end
      end
      DRAIN: begin
        if (accept && last_beat) begin
          if (lat_rise) begin
            take_line = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign overrun = lat_rise && !take_line;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg       <= '0;
      cnt         <= '0;
      lbuf        <= '0;
      addr_q      <= '0;
      beat        <= '0;
      err_len     <= 1'b0;
      err_overrun <= 1'b0;
      err_oe      <= 1'b0;
    end else begin
      shreg <= shreg_nxt;
      cnt   <= lat_rise ? '0 : cnt_nxt;
      if (lat_rise && (cnt_nxt != CNT_FULL)) begin
        err_len <= 1'b1;
      end
      if (lat_rise && !oe_lvl) begin
        err_oe <= 1'b1;
      end
      if (overrun) begin
        err_overrun <= 1'b1;
      end
      if (take_line) begin
        lbuf   <= shreg_nxt;
        addr_q <= addr_s;
        beat   <= '0;
      end else if (accept) begin
        beat <= beat + BEAT_ONE;
      end
    end
  end

  logic          half;
  logic [CW-1:0] col;

  assign half      = beat[0];
  assign col       = beat[CW:1];
  assign px_valid  = (state_q == DRAIN);
  assign px_col    = col;
  assign px_row    = {half, addr_q};
  assign px_rgb    = half ? lbuf[col][5:3] : lbuf[col][2:0];
  assign line_done = accept && last_beat;

endmodule

// File: tb/tb_hub75_panel_rx.sv
// tb/tb_hub75_panel_rx.sv - self-checking bench for hub75_panel_rx
module tb_hub75_panel_rx;

  localparam int COLS  = 32;
  localparam int ROW_W = 4;
  localparam int CW    = 5;
  localparam int BW    = ROW_W + CW + 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             hub_clk = 1'b0;
  logic             hub_lat = 1'b0;
  logic             hub_oe = 1'b1;
  logic [ROW_W-1:0] hub_addr = '0;
  logic [2:0]       hub_rgb0 = '0;
  logic [2:0]       hub_rgb1 = '0;
  logic             px_ready = 1'b0;
  logic             px_valid;
  logic [ROW_W:0]   px_row;
  logic [CW-1:0]    px_col;
  logic [2:0]       px_rgb;
  logic             line_done;
  logic             err_len;
  logic             err_overrun;
  logic             err_oe;

  hub75_panel_rx #(.COLS(COLS), .ROW_W(ROW_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .hub_clk     (hub_clk),
    .hub_lat     (hub_lat),
    .hub_oe      (hub_oe),
    .hub_addr    (hub_addr),
    .hub_rgb0    (hub_rgb0),
    .hub_rgb1    (hub_rgb1),
    .px_valid    (px_valid),
    .px_ready    (px_ready),
    .px_row      (px_row),
    .px_col      (px_col),
    .px_rgb      (px_rgb),
    .line_done   (line_done),
    .err_len     (err_len),
    .err_overrun (err_overrun),
    .err_oe      (err_oe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: full pixel history since reset; a latch takes the newest COLS pixels.
  logic [5:0]       hist[$];
  logic [5:0]       exp_line[COLS];
  logic [ROW_W-1:0] exp_addr;
  int               shifts;
  bit               busy;
  bit               e_len, e_ovr, e_oe;
  int               lat_cyc;

  logic [BW-1:0] cap_beat[$];
  int            cap_vcyc, cap_done, cap_unstable, cap_lat;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < COLS; i++) hist.push_back(6'd0);
    shifts = 0;
    busy   = 1'b0;
    e_len  = 1'b0;
    e_ovr  = 1'b0;
    e_oe   = 1'b0;
  endtask

  function automatic logic [BW-1:0] exp_beat(input int k);
    int         col;
    logic       half;
    logic [5:0] p;
    col  = k / 2;
    half = 1'(k % 2);
    p    = exp_line[col];
    return {half, exp_addr, CW'(col), half ? p[5:3] : p[2:0]};
  endfunction

  task automatic hub_shift(input logic [5:0] pix);
    @(negedge clk);
    hub_rgb0 = pix[2:0];
    hub_rgb1 = pix[5:3];
    repeat (3) @(negedge clk);
    hub_clk = 1'b1;
    repeat (4) @(negedge clk);
    hub_clk = 1'b0;
    repeat (2) @(negedge clk);
    hist.push_back(pix);
    shifts++;
  endtask

  task automatic shift_line(input int n, input bit pattern);
    logic [2:0] v;
    for (int i = 0; i < n; i++) begin
      v = 3'(i % 8);
      if (pattern) hub_shift({v, v});
      else hub_shift(6'($urandom));
    end
  endtask

  task automatic hub_latch(input logic [ROW_W-1:0] addr, input logic oe);
    @(negedge clk);
    hub_addr = addr;
    hub_oe   = oe;
    repeat (3) @(negedge clk);
    if (shifts != COLS) e_len = 1'b1;
    if (!oe) e_oe = 1'b1;
    if (busy) e_ovr = 1'b1;
    else begin
      for (int c = 0; c < COLS; c++) exp_line[c] = hist[hist.size() - COLS + c];
      exp_addr = addr;
      busy     = 1'b1;
    end
    shifts  = 0;
    hub_lat = 1'b1;
    lat_cyc = cyc;
    repeat (4) @(negedge clk);
    hub_lat = 1'b0;
    hub_oe  = 1'b1;
    @(negedge clk);
  endtask

  // mode 0: ready held high; 1: ready 0,1,0,1 per valid cycle; 2: random ready
  task automatic capture(input int mode, input int budget);
    int            c;
    bit            held;
    logic [BW-1:0] prev;
    logic [BW-1:0] cur;
    c    = 0;
    held = 1'b0;
    prev = '0;
    cap_beat.delete();
    cap_vcyc     = 0;
    cap_done     = 0;
    cap_unstable = 0;
    cap_lat      = -1;
    while (cap_beat.size() < 2 * COLS && c < budget) begin
      @(negedge clk);
      c++;
      if (mode == 0) px_ready = 1'b1;
      else if (mode == 1) px_ready = px_valid && (cap_vcyc % 2 == 1);
      else px_ready = 1'($urandom_range(0, 1));
      #1;
      cur = {px_row, px_col, px_rgb};
      if (px_valid) begin
        if (cap_lat < 0) cap_lat = cyc - lat_cyc;
        if (held && cur !== prev) cap_unstable++;
        if (px_ready) cap_beat.push_back(cur);
        held = !px_ready;
        prev = cur;
        cap_vcyc++;
      end else begin
        held = 1'b0;
      end
      if (line_done) cap_done++;
    end
    if (cap_beat.size() == 2 * COLS) busy = 1'b0;
    @(posedge clk);
    #1;
    px_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (px_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", px_valid);
    else n_pass++;
    n_checks++;
    if (line_done !== 1'b0) $display("FAIL reset_line_done: got %b expected 0", line_done);
    else n_pass++;
    n_checks++;
    if ({px_row, px_col, px_rgb} !== '0) $display("FAIL reset_beat: got %h expected 0", {px_row, px_col, px_rgb});
    else n_pass++;
    n_checks++;
    if ({err_len, err_overrun, err_oe} !== 3'b000) $display("FAIL reset_errs: got %b expected 000", {err_len, err_overrun, err_oe});
    else n_pass++;
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic(input string tag);
    shift_line(COLS, 1'b1);
    fork
      hub_latch(4'd5, 1'b1);
      capture(0, 400);
    join
    n_checks++;
    if (cap_beat.size() !== 2 * COLS) $display("FAIL %s_count: got %0d expected %0d", tag, cap_beat.size(), 2 * COLS);
    else n_pass++;
    n_checks++;
    if (cap_lat < 0 || cap_lat > 4) $display("FAIL %s_latency: got %0d expected <=4", tag, cap_lat);
    else n_pass++;
    n_checks++;
    if (cap_beat[0] !== {5'd5, 5'd0, 3'd0}) $display("FAIL %s_first: got %h expected %h", tag, cap_beat[0], {5'd5, 5'd0, 3'd0});
    else n_pass++;
    n_checks++;
    if (cap_beat[1] !== {5'd21, 5'd0, 3'd0}) $display("FAIL %s_second: got %h expected %h", tag, cap_beat[1], {5'd21, 5'd0, 3'd0});
    else n_pass++;
    n_checks++;
    if (cap_beat[63] !== {5'd21, 5'd31, 3'd7}) $display("FAIL %s_last: got %h expected %h", tag, cap_beat[63], {5'd21, 5'd31, 3'd7});
    else n_pass++;
    for (int k = 0; k < 2 * COLS; k++) begin
      n_checks++;
      if (cap_beat[k] !== exp_beat(k)) $display("FAIL %s_beat%0d: got %h expected %h", tag, k, cap_beat[k], exp_beat(k));
      else n_pass++;
    end
    n_checks++;
    if (cap_done !== 1) $display("FAIL %s_line_done: got %0d pulses expected 1", tag, cap_done);
    else n_pass++;
    n_checks++;
    if ({err_len, err_overrun, err_oe} !== 3'b000) $display("FAIL %s_errs: got %b expected 000", tag, {err_len, err_overrun, err_oe});
    else n_pass++;
  endtask

  task automatic test_stall();
    shift_line(COLS, 1'b0);
    fork
      hub_latch(4'($urandom), 1'b1);
      capture(1, 400);
    join
    n_checks++;
    if (cap_vcyc !== 4 * COLS) $display("FAIL stall_cycles: got %0d expected %0d", cap_vcyc, 4 * COLS);
    else n_pass++;
    n_checks++;
    if (cap_unstable !== 0) $display("FAIL stall_stable: got %0d changes expected 0", cap_unstable);
    else n_pass++;
    for (int k = 0; k < 2 * COLS; k++) begin
      n_checks++;
      if (cap_beat[k] !== exp_beat(k)) $display("FAIL stall_beat%0d: got %h expected %h", k, cap_beat[k], exp_beat(k));
      else n_pass++;
    end
    n_checks++;
    if (cap_done !== 1) $display("FAIL stall_line_done: got %0d pulses expected 1", cap_done);
    else n_pass++;
  endtask

  task automatic test_random();
    shift_line(COLS, 1'b0);
    fork
      hub_latch(4'($urandom), 1'b1);
      capture(2, 1000);
    join
    n_checks++;
    if (cap_unstable !== 0) $display("FAIL random_stable: got %0d changes expected 0", cap_unstable);
    else n_pass++;
    for (int k = 0; k < 2 * COLS; k++) begin
      n_checks++;
      if (cap_beat[k] !== exp_beat(k)) $display("FAIL random_beat%0d: got %h expected %h", k, cap_beat[k], exp_beat(k));
      else n_pass++;
    end
    n_checks++;
    if ({err_len, err_overrun, err_oe} !== {e_len, e_ovr, e_oe}) $display("FAIL random_errs: got %b expected %b", {err_len, err_overrun, err_oe}, {e_len, e_ovr, e_oe});
    else n_pass++;
  endtask

  task automatic test_short();
    shift_line(COLS - 1, 1'b0);
    fork
      hub_latch(4'($urandom), 1'b1);
      capture(0, 400);
    join
    n_checks++;
    if (cap_beat.size() !== 2 * COLS) $display("FAIL short_count: got %0d expected %0d", cap_beat.size(), 2 * COLS);
    else n_pass++;
    n_checks++;
    if (err_len !== 1'b1) $display("FAIL short_err_len: got %b expected 1", err_len);
    else n_pass++;
    n_checks++;
    if (cap_beat[2 * COLS - 1] !== exp_beat(2 * COLS - 1)) $display("FAIL short_last: got %h expected %h", cap_beat[2 * COLS - 1], exp_beat(2 * COLS - 1));
    else n_pass++;
    n_checks++;
    if (cap_done !== 1) $display("FAIL short_line_done: got %0d pulses expected 1", cap_done);
    else n_pass++;
  endtask

  task automatic test_overrun();
    logic [ROW_W-1:0] a;
    a = 4'($urandom);
    shift_line(COLS, 1'b0);
    hub_latch(a, 1'b1);
    n_checks++;
    if (px_valid !== 1'b1) $display("FAIL overrun_valid: got %b expected 1", px_valid);
    else n_pass++;
    n_checks++;
    if ({px_row, px_col, px_rgb} !== exp_beat(0)) $display("FAIL overrun_hold0: got %h expected %h", {px_row, px_col, px_rgb}, exp_beat(0));
    else n_pass++;
    shift_line(COLS, 1'b0);
    hub_latch(~a, 1'b1);
    repeat (2) @(negedge clk);
    n_checks++;
    if (err_overrun !== 1'b1) $display("FAIL overrun_flag: got %b expected 1", err_overrun);
    else n_pass++;
    n_checks++;
    if ({px_row, px_col, px_rgb} !== exp_beat(0)) $display("FAIL overrun_hold1: got %h expected %h", {px_row, px_col, px_rgb}, exp_beat(0));
    else n_pass++;
    capture(0, 200);
    for (int k = 0; k < 2 * COLS; k++) begin
      n_checks++;
      if (cap_beat[k] !== exp_beat(k)) $display("FAIL overrun_beat%0d: got %h expected %h", k, cap_beat[k], exp_beat(k));
      else n_pass++;
    end
    n_checks++;
    if ({err_len, err_overrun, err_oe} !== {e_len, e_ovr, e_oe}) $display("FAIL overrun_errs: got %b expected %b", {err_len, err_overrun, err_oe}, {e_len, e_ovr, e_oe});
    else n_pass++;
  endtask

  task automatic test_oe();
    shift_line(COLS, 1'b0);
    fork
      hub_latch(4'($urandom), 1'b0);
      capture(0, 400);
    join
    n_checks++;
    if (err_oe !== 1'b1) $display("FAIL oe_flag: got %b expected 1", err_oe);
    else n_pass++;
    n_checks++;
    if ({err_len, err_overrun, err_oe} !== {e_len, e_ovr, e_oe}) $display("FAIL oe_errs: got %b expected %b", {err_len, err_overrun, err_oe}, {e_len, e_ovr, e_oe});
    else n_pass++;
    n_checks++;
    if (cap_beat.size() !== 2 * COLS) $display("FAIL oe_count: got %0d expected %0d", cap_beat.size(), 2 * COLS);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int beats;
    int c;
    int seen;
    beats = 0;
    c     = 0;
    seen  = 0;
    shift_line(COLS, 1'b0);
    fork
      hub_latch(4'($urandom), 1'b1);
      while (beats < 10 && c < 200) begin
        @(negedge clk);
        px_ready = 1'b1;
        #1;
        if (px_valid) beats++;
        c++;
      end
    join
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (px_valid !== 1'b0) $display("FAIL rstmid_valid: got %b expected 0", px_valid);
    else n_pass++;
    n_checks++;
    if ({err_len, err_overrun, err_oe} !== {e_len, e_ovr, e_oe}) $display("FAIL rstmid_errs: got %b expected %b", {err_len, err_overrun, err_oe}, {e_len, e_ovr, e_oe});
    else n_pass++;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (px_valid) seen++;
    end
    px_ready = 1'b0;
    n_checks++;
    if (seen !== 0) $display("FAIL rstmid_no_beats: got %0d valid cycles expected 0", seen);
    else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic("basic");
    test_stall();
    test_random();
    test_short();
    test_overrun();
    test_oe();
    test_reset_mid();
    test_basic("recover");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
